cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one unified memory port between the multicycle RISC-V core's instruction-fetch channel and its load/store channel.
- Sits between custom_cpu and the memory/bus wrapper.
- Arbitrates requests, steers each read response back to the requester that issued it, and keeps at most one transaction outstanding.
- Also counts arbitration-stall cycles, which can feed a cpu_perf_cnt slot.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte strobe width is DATA_W/8.
- D_PRIO, 1, tie-break when both sides request in the same IDLE cycle: 1 = data side wins, 0 = round-robin against the last grant.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_addr  in  ADDR_W  fetch address (PC)
- i_req_valid  in  1  fetch request
- i_req_ack  out  1  fetch request accepted
- i_rdata  out  DATA_W  instruction word
- i_rdata_valid  out  1  instruction valid
- i_rdata_ack  in  1  core accepts instruction
- d_addr  in  ADDR_W  word-aligned data address
- d_wen  in  1  store request
- d_ren  in  1  load request
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte strobes
- d_req_ack  out  1  data request accepted
- d_rdata  out  DATA_W  load data
- d_rdata_valid  out  1  load data valid
- d_rdata_ack  in  1  core accepts load data
- m_addr  out  ADDR_W  memory address
- m_wen  out  1  memory write
- m_ren  out  1  memory read
- m_wdata  out  DATA_W  memory write data
- m_wstrb  out  DATA_W/8  memory strobes
- m_req_ack  in  1  memory accepts request
- m_rdata  in  DATA_W  memory read data
- m_rdata_valid  in  1  memory read data valid
- m_rdata_ack  out  1  arbiter accepts read data
- stall_cnt  out  32  cycles in which a requester was valid but not being served

Behaviour:
- Reset:
  - state=IDLE, last_grant=I, stall_cnt=0.
  - All ack/valid outputs are 0; m_addr, m_wdata and m_wstrb are 0.
  - Reset during any state aborts the transaction.
  - Any later m_rdata_valid arriving in IDLE is drained: m_rdata_ack=1 and the data is discarded, never forwarded.
- Request rules:
  - Requesters hold valid and payload stable until acked.
  - d_wen and d_ren are never both 1; if they are, the read is ignored and the request is treated as a write.
- States: IDLE, I_REQ, I_RESP, D_WREQ, D_RREQ, D_RESP.
- IDLE:
  - Sample the requests; no ack is given this cycle, so grant latency is 1 cycle.
  - Only d_ren/d_wen valid -> D_RREQ or D_WREQ.
  - Only i_req_valid -> I_REQ.
  - Both valid -> resolve by D_PRIO/last_grant; last_grant is updated at grant time.
- I_REQ:
  - m_ren=1, m_addr=i_req_addr, i_req_ack=m_req_ack.
  - On m_req_ack -> I_RESP.
- I_RESP:
  - i_rdata=m_rdata, i_rdata_valid=m_rdata_valid, m_rdata_ack=i_rdata_ack.
  - On m_rdata_valid&i_rdata_ack -> IDLE.
- D_WREQ:
  - m_wen=1; m_addr, m_wdata and m_wstrb pass through from the data side.
  - d_req_ack=m_req_ack.
  - On ack -> IDLE; a store has no response phase.
- D_RREQ:
  - m_ren=1, m_addr=d_addr, d_req_ack=m_req_ack.
  - On ack -> D_RESP.
- D_RESP: mirror of I_RESP onto the d_rdata* signals.
- Gating and ordering:
  - Request and response outputs are combinational pass-throughs, gated by state.
  - The non-granted side sees ack=0 and valid=0.
  - An ungranted request stays pending and is taken at the next IDLE.
  - In I_RESP/D_RESP, m_rdata_valid without the consumer's ack holds the state; no data is lost.
- stall_cnt:
  - Increments by 1 each cycle in which (i_req_valid & state not in {I_REQ, I_RESP}) or ((d_ren|d_wen) & state not in {D_WREQ, D_RREQ, D_RESP}).
  - The IDLE grant cycle counts as a stall.
  - Wraps modulo 2^32.
- Maximum throughput is one transaction per 2 + memory-latency cycles.

Decomposition:
- Shared package holds:
  - the state encoding (one-hot, 6 bits);
  - the grant encoding (GNT_I=0, GNT_D=1);
  - default widths.
- One natural sub-module, arb_pick: 2-way priority/round-robin picker (req[1:0], last, d_prio -> gnt). Everything else is inline.

Test Plan:
- Fetch only: i_req_valid, addr 0x100, memory returns 0x00500093 two cycles after ack -> m_ren=1, m_addr=0x100 in I_REQ; i_rdata=0x00500093 with i_rdata_valid; back in IDLE; stall_cnt=1.
- Store: d_wen, addr 0x2000, wdata 0xDEADBEEF, wstrb 4'b0011 -> m_wen=1 with identical payload; d_req_ack on m_req_ack; no D_RESP; m_ren=0 throughout.
- Contention, D_PRIO=1: fetch 0x104 and load 0x3000 both valid in IDLE -> load is granted first and d_rdata returns the value; fetch is served next; i_req_ack stays 0 until I_REQ.
- Contention, D_PRIO=0, 3 consecutive back-to-back double requests -> grants alternate D, I, D starting from last_grant=I after reset.
- Backpressure: memory holds m_req_ack=0 for 5 cycles, then the core holds i_rdata_ack=0 for 3 cycles after valid -> state holds, m_rdata_ack mirrors i_rdata_ack, exactly one response delivered.
- Reset mid-I_RESP, then m_rdata_valid arrives in IDLE -> m_rdata_ack=1, i_rdata_valid=0, stall_cnt=0.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// ============================================================================
// Package  : cpu_mem_arbiter_pkg
// Brief    : Shared state/grant encodings and default widths for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_arbiter_pkg;

    localparam int C_DEF_ADDR_W = 32;
    localparam int C_DEF_DATA_W = 32;
    localparam int C_STALL_W    = 32;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_I_REQ  = 6'b000010,
        ST_I_RESP = 6'b000100,
        ST_D_WREQ = 6'b001000,
        ST_D_RREQ = 6'b010000,
        ST_D_RESP = 6'b100000
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/cpu_mem_arbiter_arb_pick.sv
// ============================================================================
// Module   : arb_pick
// Brief    : Two-way picker, fixed data priority or round-robin on a tie.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
    import cpu_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,     // [1] = data side, [0] = fetch side
    input  grant_t     last,
    input  logic       d_prio,
    output grant_t     gnt
);

    always_comb begin
        gnt = GNT_I;
        case (req)
            2'b01:   gnt = GNT_I;
            2'b10:   gnt = GNT_D;
            2'b11:   gnt = (d_prio || (last == GNT_I)) ? GNT_D : GNT_I;
            default: gnt = last;    // no requester; result is ignored
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
// ============================================================================
// Module   : cpu_mem_arbiter
// Brief    : Shares one memory port between fetch and load/store channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = C_DEF_ADDR_W,
    parameter int DATA_W = C_DEF_DATA_W,
    parameter int D_PRIO = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic                  i_req_valid,
    output logic                  i_req_ack,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_rdata_valid,
    input  logic                  i_rdata_ack,

    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_wen,
    input  logic                  d_ren,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_req_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_rdata_valid,
    input  logic                  d_rdata_ack,

    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_wen,
    output logic                  m_ren,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_req_ack,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_rdata_valid,
    output logic                  m_rdata_ack,

    output logic [C_STALL_W-1:0]  stall_cnt
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    grant_t                 r_last_grant;
    grant_t                 w_gnt;
    logic [C_STALL_W-1:0]   r_stall_cnt;
    logic                   w_d_req;
    logic                   w_any_req;
    logic                   w_i_stall;
    logic                   w_d_stall;

    assign w_d_req   = d_wen | d_ren;
    assign w_any_req = w_d_req | i_req_valid;

    arb_pick u_arb_pick (
        .req    ({w_d_req, i_req_valid}),
        .last   (r_last_grant),
        .d_prio (D_PRIO != 0),
        .gnt    (w_gnt)
    );

    // A requester is stalled whenever it is valid but its own states are not active.
    assign w_i_stall = i_req_valid &
                       ~((r_state == ST_I_REQ) | (r_state == ST_I_RESP));
    assign w_d_stall = w_d_req &
                       ~((r_state == ST_D_WREQ) | (r_state == ST_D_RREQ) |
                         (r_state == ST_D_RESP));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_I;
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_last_grant <= w_gnt;
            end
            if (w_i_stall | w_d_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        i_req_ack     = 1'b0;
        i_rdata       = '0;
        i_rdata_valid = 1'b0;
        d_req_ack     = 1'b0;
        d_rdata       = '0;
        d_rdata_valid = 1'b0;
        m_addr        = '0;
        m_wen         = 1'b0;
        m_ren         = 1'b0;
        m_wdata       = '0;
        m_wstrb       = '0;
        m_rdata_ack   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Stray read data (e.g. after a reset mid-response) is drained here.
                m_rdata_ack = m_rdata_valid;
                if (w_any_req) begin
                    if (w_gnt == GNT_D) begin
                        w_state_nxt = d_wen ? ST_D_WREQ : ST_D_RREQ;
                    end else begin
                        w_state_nxt = ST_I_REQ;
                    end
                end
            end

            ST_I_REQ: begin
                m_ren     = 1'b1;
                m_addr    = i_req_addr;
                i_req_ack = m_req_ack;
                if (m_req_ack) begin
                    w_state_nxt = ST_I_RESP;
                end
            end

            ST_I_RESP: begin
                i_rdata       = m_rdata;
                i_rdata_valid = m_rdata_valid;
                m_rdata_ack   = i_rdata_ack;
                if (m_rdata_valid && i_rdata_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_D_WREQ: begin
                m_wen     = 1'b1;
                m_addr    = d_addr;
                m_wdata   = d_wdata;
                m_wstrb   = d_wstrb;
                d_req_ack = m_req_ack;
                if (m_req_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_D_RREQ: begin
                m_ren     = 1'b1;
                m_addr    = d_addr;
                d_req_ack = m_req_ack;
                if (m_req_ack) begin
                    w_state_nxt = ST_D_RESP;
                end
            end

            ST_D_RESP: begin
                d_rdata       = m_rdata;
                d_rdata_valid = m_rdata_valid;
                m_rdata_ack   = d_rdata_ack;
                if (m_rdata_valid && d_rdata_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Brief    : Scoreboard bench for cpu_mem_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] i_req_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        i_req_valid, i_req_ack, i_rdata_valid, i_rdata_ack;
    logic        d_wen, d_ren, d_req_ack, d_rdata_valid, d_rdata_ack;
    logic [3:0]  d_wstrb, m_wstrb;
    logic        m_wen, m_ren, m_req_ack, m_rdata_valid, m_rdata_ack;
    logic [31:0] stall_cnt;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(1)) dut (
        .clk(clk), .rst(rst),
        .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_ack(i_req_ack),
        .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid), .i_rdata_ack(i_rdata_ack),
        .d_addr(d_addr), .d_wen(d_wen), .d_ren(d_ren), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_req_ack(d_req_ack), .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
        .d_rdata_ack(d_rdata_ack),
        .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_req_ack(m_req_ack), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
        .m_rdata_ack(m_rdata_ack), .stall_cnt(stall_cnt)
    );

    // Second instance exercising the round-robin tie-break.
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
    logic [3:0]  rr_m_wstrb;
    logic        rr_i_req_valid, rr_d_ren, rr_i_req_ack, rr_d_req_ack;
    logic        rr_i_rdata_valid, rr_d_rdata_valid, rr_m_wen, rr_m_ren, rr_m_rdata_ack;
    logic [31:0] rr_stall_cnt;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req_addr(32'h80), .i_req_valid(rr_i_req_valid), .i_req_ack(rr_i_req_ack),
        .i_rdata(rr_i_rdata), .i_rdata_valid(rr_i_rdata_valid), .i_rdata_ack(1'b1),
        .d_addr(32'h40), .d_wen(1'b0), .d_ren(rr_d_ren), .d_wdata(32'h0), .d_wstrb(4'h0),
        .d_req_ack(rr_d_req_ack), .d_rdata(rr_d_rdata), .d_rdata_valid(rr_d_rdata_valid),
        .d_rdata_ack(1'b1),
        .m_addr(rr_m_addr), .m_wen(rr_m_wen), .m_ren(rr_m_ren), .m_wdata(rr_m_wdata),
        .m_wstrb(rr_m_wstrb), .m_req_ack(1'b1), .m_rdata(32'h5A5A5A5A), .m_rdata_valid(1'b1),
        .m_rdata_ack(rr_m_rdata_ack), .stall_cnt(rr_stall_cnt)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int i_resp_cnt = 0;
    int rr_seen = 0;
    int ack_delay = 0;
    int rd_lat = 2;

    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_raddr_q[$];
    logic [67:0] exp_w_q[$];
    bit          exp_gnt_q[$];   // 1 = data side
    bit          rr_exp_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100:  return 32'h00500093;
            32'h104:  return 32'h00A00113;
            32'h108:  return 32'h12345678;
            32'h3000: return 32'hCAFEF00D;
            default:  return 32'hBAD0BAD0;
        endcase
    endfunction

    // Behavioural memory: one request at a time, configurable ack delay and read latency.
    initial begin : mem_model
        logic        is_rd;
        logic        got;
        logic [31:0] a;
        int          n;
        m_req_ack = 1'b0;
        m_rdata_valid = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (m_ren || m_wen)) begin
                is_rd = m_ren;
                a = m_addr;
                for (int k = 0; k < ack_delay; k++) begin
                    @(posedge clk);
                    #1;
                end
                m_req_ack = 1'b1;
                @(posedge clk);
                #1;
                m_req_ack = 1'b0;
                if (is_rd) begin
                    for (int k = 0; k < rd_lat; k++) begin
                        @(posedge clk);
                        #1;
                    end
                    m_rdata = mem_word(a);
                    m_rdata_valid = 1'b1;
                    got = 1'b0;
                    n = 0;
                    while (!got && n < 200) begin
                        @(negedge clk);
                        got = m_rdata_ack;
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    m_rdata_valid = 1'b0;
                    m_rdata = '0;
                end
            end
        end
    end

    task automatic core_fetch(input logic [31:0] a, output int cyc);
        logic got;
        cyc = 0;
        got = 1'b0;
        i_req_addr = a;
        i_req_valid = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            got = i_req_ack;
            cyc++;
            @(posedge clk);
            #1;
        end
        if (!got) check("fetch_ack_timeout", 96'(0), 96'(1));
        i_req_valid = 1'b0;
        i_req_addr = '0;
    endtask

    task automatic core_data(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        d_addr = a;
        d_wdata = wd;
        d_wstrb = st;
        d_wen = wr;
        d_ren = ~wr;
        while (!got && n < 100) begin
            @(negedge clk);
            got = d_req_ack;
            n++;
            @(posedge clk);
            #1;
        end
        if (!got) check("data_ack_timeout", 96'(0), 96'(1));
        d_wen = 1'b0;
        d_ren = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        d_wstrb = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_i_q.size() + exp_d_q.size() + exp_raddr_q.size() + exp_w_q.size()
                + exp_gnt_q.size()) != 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) check("drain_timeout", 96'(0), 96'(1));
        tick(2);
    endtask

    // Monitor: pops expected transactions whenever the DUT completes a handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_rdata_valid && i_rdata_ack) begin
                i_resp_cnt++;
                if (exp_i_q.size() == 0) check("unexpected_i_resp", 96'(i_rdata), 96'(0) - 96'(1));
                else check("i_rdata", 96'(i_rdata), 96'(exp_i_q.pop_front()));
            end
            if (d_rdata_valid && d_rdata_ack) begin
                if (exp_d_q.size() == 0) check("unexpected_d_resp", 96'(d_rdata), 96'(0) - 96'(1));
                else check("d_rdata", 96'(d_rdata), 96'(exp_d_q.pop_front()));
            end
            if (m_ren && m_req_ack) begin
                if (exp_raddr_q.size() == 0) check("unexpected_mem_read", 96'(m_addr), 96'(0) - 96'(1));
                else check("m_read_addr", 96'({m_wen, m_addr}), 96'({1'b0, exp_raddr_q.pop_front()}));
            end
            if (m_wen && m_req_ack) begin
                if (exp_w_q.size() == 0) check("unexpected_mem_write", 96'(m_addr), 96'(0) - 96'(1));
                else check("m_write_payload", 96'({m_ren, m_addr, m_wdata, m_wstrb}),
                           96'({1'b0, exp_w_q.pop_front()}));
            end
            if (i_req_ack || d_req_ack) begin
                if (exp_gnt_q.size() == 0) check("unexpected_grant", 96'({i_req_ack, d_req_ack}), 96'(0));
                else check("grant_order", 96'({i_req_ack, d_req_ack}),
                           exp_gnt_q.pop_front() ? 96'(2'b01) : 96'(2'b10));
            end
            if (rr_exp_q.size() != 0 && (rr_i_req_ack || rr_d_req_ack)) begin
                rr_seen++;
                check("rr_grant", 96'({rr_i_req_ack, rr_d_req_ack}),
                      rr_exp_q.pop_front() ? 96'(2'b01) : 96'(2'b10));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int  c;
        int  r0;
        int  n;
        logic found;

        rst = 1'b1;
        i_req_addr = '0; i_req_valid = 1'b0; i_rdata_ack = 1'b1;
        d_addr = '0; d_wen = 1'b0; d_ren = 1'b0; d_wdata = '0; d_wstrb = '0; d_rdata_ack = 1'b1;
        rr_i_req_valid = 1'b0; rr_d_ren = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_acks_valids", 96'({i_req_ack, d_req_ack, i_rdata_valid, d_rdata_valid,
                                        m_rdata_ack, m_ren, m_wen}), 96'(0));
        check("reset_m_addr", 96'(m_addr), 96'(0));
        check("reset_m_wdata", 96'(m_wdata), 96'(0));
        check("reset_m_wstrb", 96'(m_wstrb), 96'(0));
        check("reset_stall_cnt", 96'(stall_cnt), 96'(0));
        tick(1);

        // Fetch only
        ack_delay = 0; rd_lat = 2;
        exp_gnt_q.push_back(1'b0);
        exp_raddr_q.push_back(32'h100);
        exp_i_q.push_back(32'h00500093);
        core_fetch(32'h100, c);
        check("fetch_grant_latency", 96'(c), 96'(2));
        wait_drain();
        check("stall_after_fetch", 96'(stall_cnt), 96'(1));

        // Store
        exp_gnt_q.push_back(1'b1);
        exp_w_q.push_back({32'h2000, 32'hDEADBEEF, 4'b0011});
        core_data(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011);
        wait_drain();
        tick(2);
        check("stall_after_store", 96'(stall_cnt), 96'(2));

        // Contention with data priority: load first, then fetch
        exp_gnt_q.push_back(1'b1);
        exp_gnt_q.push_back(1'b0);
        exp_raddr_q.push_back(32'h3000);
        exp_raddr_q.push_back(32'h104);
        exp_d_q.push_back(32'hCAFEF00D);
        exp_i_q.push_back(32'h00A00113);
        fork
            core_fetch(32'h104, c);
            core_data(1'b0, 32'h3000, 32'h0, 4'h0);
            begin
                found = 1'b0;
                n = 0;
                while (!found && n < 100) begin
                    @(negedge clk);
                    found = d_rdata_valid;
                    n++;
                    if (found) check("fetch_blocked_during_load", 96'({i_req_ack, i_rdata_valid}), 96'(0));
                    @(posedge clk);
                    #1;
                end
                if (!found) check("load_resp_timeout", 96'(0), 96'(1));
            end
        join
        wait_drain();
        check("stall_after_contention", 96'(stall_cnt), 96'(8));

        // Backpressure on request and response
        ack_delay = 5; rd_lat = 1;
        i_rdata_ack = 1'b0;
        r0 = i_resp_cnt;
        exp_gnt_q.push_back(1'b0);
        exp_raddr_q.push_back(32'h108);
        exp_i_q.push_back(32'h12345678);
        fork
            core_fetch(32'h108, c);
            begin
                found = 1'b0;
                n = 0;
                while (!found && n < 100) begin
                    @(negedge clk);
                    found = i_rdata_valid;
                    n++;
                    if (!found) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (!found) check("bp_resp_timeout", 96'(0), 96'(1));
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    check("bp_m_rdata_ack_low", 96'(m_rdata_ack), 96'(0));
                    check("bp_valid_held", 96'({i_rdata_valid, i_rdata}), 96'({1'b1, 32'h12345678}));
                    @(posedge clk);
                    #1;
                end
                i_rdata_ack = 1'b1;
                @(negedge clk);
                check("bp_m_rdata_ack_high", 96'(m_rdata_ack), 96'(1));
                @(posedge clk);
                #1;
            end
        join
        check("bp_grant_latency", 96'(c), 96'(7));
        wait_drain();
        tick(3);
        check("bp_single_response", 96'(i_resp_cnt - r0), 96'(1));
        check("stall_after_bp", 96'(stall_cnt), 96'(9));
        ack_delay = 0;

        // Reset while waiting in I_RESP, then late read data must be drained
        rd_lat = 6;
        exp_gnt_q.push_back(1'b0);
        exp_raddr_q.push_back(32'h10C);
        core_fetch(32'h10C, c);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            found = m_rdata_valid;
            n++;
            if (found) begin
                check("drain_m_rdata_ack", 96'(m_rdata_ack), 96'(1));
                check("drain_no_forward", 96'({i_rdata_valid, d_rdata_valid}), 96'(0));
                check("drain_stall_cnt", 96'(stall_cnt), 96'(0));
            end
            @(posedge clk);
            #1;
        end
        if (!found) check("drain_timeout", 96'(0), 96'(1));
        tick(3);
        rd_lat = 2;

        // Round-robin instance: back-to-back double requests alternate D, I, D
        rr_exp_q.push_back(1'b1);
        rr_exp_q.push_back(1'b0);
        rr_exp_q.push_back(1'b1);
        rr_i_req_valid = 1'b1;
        rr_d_ren = 1'b1;
        n = 0;
        while (rr_seen < 3 && n < 100) begin
            tick(1);
            n++;
        end
        if (rr_seen < 3) check("rr_timeout", 96'(rr_seen), 96'(3));
        rr_i_req_valid = 1'b0;
        rr_d_ren = 1'b0;
        tick(4);

        check("leftover_expectations", 96'(exp_i_q.size() + exp_d_q.size() + exp_raddr_q.size()
                                            + exp_w_q.size() + exp_gnt_q.size() + rr_exp_q.size()),
              96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
